// File: rtl/vga_plot_arbiter.sv
// -----------------------------------------------------------------------------
// vga_plot_arbiter
//
// Purpose:
//   Shares one VGA adapter write port between two pixel engines. Engine 0 is
//   the fill engine and engine 1 is the circle engine. An engine first asks for
//   a session (reqN). Once it holds the grant (gntN), its plot strobes are
//   range-checked. In-range pixels go to the adapter one cycle later.
//   Out-of-range pixels are dropped and counted. The engine ends its session
//   with relN. After every session the arbiter spends one cycle idle before it
//   can grant again. When both engines request together in IDLE, the grant
//   alternates between them (round-robin).
//
// Ports:
//   clk                 single clock, rising edge
//   rst                 synchronous active-high reset
//   req0/req1           session request from engine 0 / 1
//   rel0/rel1           session release from engine 0 / 1
//   x0/x1   [7:0]       pixel x from engine 0 / 1
//   y0/y1   [6:0]       pixel y from engine 0 / 1
//   c0/c1   [2:0]       pixel colour from engine 0 / 1
//   plot0/plot1         pixel write strobe from engine 0 / 1
//   gnt0/gnt1           registered session grant (one-hot or zero)
//   vga_x   [7:0]       registered adapter x
//   vga_y   [6:0]       registered adapter y
//   vga_colour [2:0]    registered adapter colour
//   vga_plot            registered adapter write strobe
//   pix_count [14:0]    pixels forwarded in the current or last session
//   drop_count [15:0]   out-of-range plots discarded since reset
// -----------------------------------------------------------------------------
module vga_plot_arbiter #(
    parameter int unsigned XMAX = 160,
    parameter int unsigned YMAX = 120
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        req0,
    input  logic        req1,
    input  logic        rel0,
    input  logic        rel1,
    input  logic [7:0]  x0,
    input  logic [7:0]  x1,
    input  logic [6:0]  y0,
    input  logic [6:0]  y1,
    input  logic [2:0]  c0,
    input  logic [2:0]  c1,
    input  logic        plot0,
    input  logic        plot1,
    output logic        gnt0,
    output logic        gnt1,
    output logic [7:0]  vga_x,
    output logic [6:0]  vga_y,
    output logic [2:0]  vga_colour,
    output logic        vga_plot,
    output logic [14:0] pix_count,
    output logic [15:0] drop_count
);

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        BUSY0 = 2'd1,
        BUSY1 = 2'd2
    } state_t;

    localparam logic [14:0] PIX_MAX  = 15'h7FFF;
    localparam logic [15:0] DROP_MAX = 16'hFFFF;

    state_t      state_q;
    logic        last_served_q;
    logic        gnt0_q;
    logic        gnt1_q;
    logic [7:0]  vga_x_q;
    logic [6:0]  vga_y_q;
    logic [2:0]  vga_colour_q;
    logic        vga_plot_q;
    logic [14:0] pix_count_q;
    logic [14:0] pix_count_d;
    logic [15:0] drop_count_q;
    logic [15:0] drop_count_d;

    // Per-engine views so that both engines share the same range-check logic.
    logic [7:0] x_arr    [2];
    logic [6:0] y_arr    [2];
    logic [2:0] c_arr    [2];
    logic [1:0] plot_arr;
    logic [1:0] gnt_arr;
    logic [1:0] in_range;

    assign x_arr[0]    = x0;
    assign x_arr[1]    = x1;
    assign y_arr[0]    = y0;
    assign y_arr[1]    = y1;
    assign c_arr[0]    = c0;
    assign c_arr[1]    = c1;
    assign plot_arr[0] = plot0;
    assign plot_arr[1] = plot1;
    assign gnt_arr[0]  = gnt0_q;
    assign gnt_arr[1]  = gnt1_q;

    genvar gi;
    generate
        for (gi = 0; gi < 2; gi++) begin : g_range
            assign in_range[gi] = (32'(x_arr[gi]) < XMAX) && (32'(y_arr[gi]) < YMAX);
        end
    endgenerate

    // Only the granted engine's strobe is seen. With no grant, both strobes
    // are masked, so a stray plot or release has no effect.
    logic       sel_eng;
    logic       sel_plot;
    logic       fwd;
    logic       drop;

    always_comb begin
        sel_eng  = gnt1_q;
        sel_plot = plot_arr[sel_eng] & gnt_arr[sel_eng];
        fwd      = sel_plot &  in_range[sel_eng];
        drop     = sel_plot & ~in_range[sel_eng];
    end

    always_comb begin
        pix_count_d = pix_count_q;
        if (fwd && (pix_count_q != PIX_MAX)) begin
            pix_count_d = pix_count_q + 15'd1;
        end
        drop_count_d = drop_count_q;
        if (drop && (drop_count_q != DROP_MAX)) begin
            drop_count_d = drop_count_q + 16'd1;
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q       <= IDLE;
            last_served_q <= 1'b1;
            gnt0_q        <= 1'b0;
            gnt1_q        <= 1'b0;
            vga_x_q       <= '0;
            vga_y_q       <= '0;
            vga_colour_q  <= '0;
            vga_plot_q    <= 1'b0;
            pix_count_q   <= '0;
            drop_count_q  <= '0;
        end else begin
            // Adapter port: pulse for exactly one cycle per accepted pixel,
            // coordinates held otherwise.
            vga_plot_q   <= fwd;
            if (fwd) begin
                vga_x_q      <= x_arr[sel_eng];
                vga_y_q      <= y_arr[sel_eng];
                vga_colour_q <= c_arr[sel_eng];
            end
            drop_count_q <= drop_count_d;

            case (state_q)
                IDLE: begin
                    // If both engines request, the one that was not served last
                    // gets the grant. pix_count restarts when a session begins.
                    if (req0 && (!req1 || last_served_q)) begin
                        state_q       <= BUSY0;
                        gnt0_q        <= 1'b1;
                        last_served_q <= 1'b0;
                        pix_count_q   <= '0;
                    end else if (req1) begin
                        state_q       <= BUSY1;
                        gnt1_q        <= 1'b1;
                        last_served_q <= 1'b1;
                        pix_count_q   <= '0;
                    end
                end
                BUSY0: begin
                    pix_count_q <= pix_count_d;
                    if (rel0) begin
                        state_q <= IDLE;
                        gnt0_q  <= 1'b0;
                    end
                end
                BUSY1: begin
                    pix_count_q <= pix_count_d;
                    if (rel1) begin
                        state_q <= IDLE;
                        gnt1_q  <= 1'b0;
                    end
                end
                default: begin
                    state_q <= IDLE;
                    gnt0_q  <= 1'b0;
                    gnt1_q  <= 1'b0;
                end
            endcase
        end
    end

    assign gnt0       = gnt0_q;
    assign gnt1       = gnt1_q;
    assign vga_x      = vga_x_q;
    assign vga_y      = vga_y_q;
    assign vga_colour = vga_colour_q;
    assign vga_plot   = vga_plot_q;
    assign pix_count  = pix_count_q;
    assign drop_count = drop_count_q;

endmodule

// File: doc/vga_plot_arbiter.md
VGA_PLOT_ARBITER -- requirements
Module: vga_plot_arbiter

Interface
REQ-001 Parameter XMAX, default 160, SHALL set the exclusive upper bound on plotted x.
REQ-002 Parameter YMAX, default 120, SHALL set the exclusive upper bound on plotted y.
REQ-003 clk  in  1  single clock; all state SHALL update on its rising edge.
REQ-004 rst  in  1  SHALL be a synchronous, active-high reset.
REQ-005 req0 / req1  in  1  session request from engine 0 (fill) / engine 1 (circle).
REQ-006 rel0 / rel1  in  1  session release from the granted engine.
REQ-007 x0 / x1  in  8  pixel x from each engine.
REQ-008 y0 / y1  in  7  pixel y from each engine.
REQ-009 c0 / c1  in  3  pixel colour from each engine.
REQ-010 plot0 / plot1  in  1  pixel write strobe from each engine.
REQ-011 gnt0 / gnt1  out  1  registered session grant; SHALL be one-hot or zero.
REQ-012 vga_x  out  8, vga_y  out  7, vga_colour  out  3, vga_plot  out  1  registered VGA adapter write port.
REQ-013 pix_count  out  15  pixels forwarded in the current or last session.
REQ-014 drop_count  out  16  out-of-range plots discarded since reset.

Function
REQ-015 The FSM SHALL have three states: IDLE, BUSY0 and BUSY1.
REQ-016 In IDLE with exactly one reqN high at edge k, the FSM SHALL enter BUSYN, and gntN SHALL be high from edge k onward.
REQ-017 In IDLE with req0 and req1 both high, the grant SHALL go to the engine not served last (round-robin); last_served SHALL reset to 1, so engine 0 wins first.
REQ-018 In BUSYN, reqN and the other engine's request SHALL be ignored; the grant SHALL be held until relN is sampled high.
REQ-019 relN sampled high in BUSYN SHALL clear gntN at that edge and return the FSM to IDLE; the earliest next grant SHALL be one edge later (mandatory one-cycle gap).
REQ-020 relN from a non-granted engine, and plotN while gntN is low, SHALL be ignored with no side effects.
REQ-021 plotN sampled high with gntN high and xN<XMAX and yN<YMAX SHALL cause vga_plot=1 for the following cycle, with vga_x/vga_y/vga_colour equal to the sampled xN/yN/cN (latency 1).
REQ-022 plotN sampled high with gntN high and xN>=XMAX or yN>=YMAX SHALL leave vga_plot=0 and increment drop_count, which SHALL saturate at 65535.
REQ-023 vga_plot SHALL be low in every cycle not produced by REQ-021; vga_x/vga_y/vga_colour SHALL hold their last values when vga_plot=0.
REQ-024 plotN and relN high in the same cycle SHALL forward or drop the pixel per REQ-021/022 and also release per REQ-019.
REQ-025 pix_count SHALL clear to 0 on entry to BUSYN and SHALL increment on each forwarded pixel, saturating at 32767; it SHALL hold its value in IDLE.
REQ-026 A full 160x120 fill SHALL complete with pix_count = 19200 and no saturation.

Reset
REQ-027 With rst sampled high, state SHALL be IDLE, last_served=1, and gnt0, gnt1, vga_plot, vga_x, vga_y, vga_colour, pix_count and drop_count SHALL all be 0 after that edge.
REQ-028 rst asserted in BUSYN SHALL abort the session at that edge with no pixel forwarded for that cycle's plot, and SHALL take priority over all other inputs.

Verification
REQ-029 Assert rst for 2 cycles with all requests high -> all outputs 0; first grant after rst release is gnt0.
REQ-030 req0=1 alone -> gnt0=1 next edge; then plot0 with x0=159, y0=119, c0=3'b011 -> next cycle vga_plot=1, vga_x=159, vga_y=119, vga_colour=3, pix_count=1.
REQ-031 req0=req1=1 from IDLE -> gnt0; rel0 -> gnt0=0 and one idle cycle, then gnt1=1; after rel1 with both requesting -> gnt0.
REQ-032 Granted engine 1 plots x1=160, y1=5, then x1=10, y1=120 -> vga_plot stays 0, drop_count=2, pix_count=0.
REQ-033 Engine 0 streams 19200 in-range plots, with rel0 on the final plot -> 19200 vga_plot pulses, pix_count=19200, gnt0=0 after the final edge.
REQ-034 rst pulsed mid-fill after 5000 pixels -> gnt0=0, pix_count=0, no vga_plot in the following cycle; a fresh req0 is granted normally.
